move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Upstream feeder for the two-motor stepper controller (bar motor plus magnet-carriage motor).
- Buffers a path of compass-move commands written by the host interface in a FIFO.
- Issues each move as a single-cycle one-hot direction pulse, waits for the controller's move-complete pulse, then waits a settle gap before the next move.
- Also issues homing requests, drives the electromagnet enable per move, and reports path completion.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2.
- AW, 4, log2(DEPTH).
- SETTLE_CYCLES, 1000, idle clocks between a move completing and the next pulse; minimum 1.
- TIMEOUT_CYCLES, 50000000, watchdog limit in clocks; only used with MOVE_TIMEOUT_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high block reset.
- cmd_in, in, 4: [2:0] direction code (0=N, 1=NW, 2=W, 3=SW, 4=S, 5=SE, 6=E, 7=NE); [3] magnet engage for this move.
- cmd_wr, in, 1: push cmd_in when high.
- cmd_full, out, 1: FIFO holds DEPTH entries.
- cmd_count, out, AW+1: current FIFO occupancy.
- overflow, out, 1: sticky; set when a write is dropped.
- home_req, in, 1: request a homing move (1-cycle pulse).
- abort, in, 1: flush the path (1-cycle pulse).
- direction, out, 8: one-hot move pulse to the motor controller; bit index = direction code.
- home, out, 1: 1-cycle homing pulse to the motor controller.
- move_done, in, 1: move-complete pulse from the motor controller; may be held 1-2 cycles.
- magnet_on, out, 1: electromagnet enable.
- busy, out, 1: high in any state other than IDLE.
- path_done, out, 1: 1-cycle pulse when the last queued move has settled.
- error, out, 1: timeout flag; constant 0 without MOVE_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0, FIFO empty, cmd_count 0, overflow 0, home_pending 0, state IDLE.
- FIFO:
  - A write when full is dropped and sets overflow.
  - A write and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd_count updates the cycle after a write.
- move_done is edge-detected: done_rise = move_done & ~move_done_q. Only done_rise is acted on.
- home_req in any state sets home_pending. home_pending clears when HOME_ISSUE is entered.
- State machine:
  - IDLE: if home_pending, go to HOME_ISSUE. Else if FIFO is non-empty, pop the head into cur_cmd and go to ISSUE. Else magnet_on = 0.
  - ISSUE (1 cycle): direction = 1 << cur_cmd[2:0]; magnet_on <= cur_cmd[3]; go to WAIT_DONE.
  - WAIT_DONE: direction = 0. On done_rise, load the settle counter with SETTLE_CYCLES-1 and go to SETTLE. done_rise is never sampled in the ISSUE cycle.
  - SETTLE: decrement the counter. At 0:
    - if home_pending, go to HOME_ISSUE;
    - else if FIFO is non-empty, pop and go to ISSUE (magnet_on held);
    - else pulse path_done, set magnet_on = 0 and go to IDLE.
  - HOME_ISSUE (1 cycle): home = 1; magnet_on = 0; go to HOME_WAIT.
  - HOME_WAIT: on done_rise, go to SETTLE. Homing does not itself produce path_done unless the FIFO is empty at the end of SETTLE.
- Latency: a write at cycle t into an empty FIFO while in IDLE gives direction high at cycle t+2 for exactly 1 cycle.
- abort:
  - Flushes the FIFO immediately; a same-cycle cmd_wr is dropped without setting overflow.
  - In IDLE/SETTLE: go to IDLE next cycle, magnet_on = 0, no path_done.
  - In ISSUE/WAIT_DONE/HOME_*: the motion cannot be stopped. Continue waiting for done_rise, then go straight to IDLE (no settle), magnet_on = 0, no path_done.
- reset mid-move: immediate return to reset values. The motor controller is not informed.
- Never more than one bit of direction high; direction and home are never high in the same cycle.

Optional Feature:
- MOVE_TIMEOUT_EN defined:
  - A 32-bit watchdog counts clocks in WAIT_DONE and HOME_WAIT.
  - On reaching TIMEOUT_CYCLES: set error (sticky), flush the FIFO, magnet_on = 0, enter ERROR.
  - ERROR leaves only on reset; busy = 1 in ERROR.
- MOVE_TIMEOUT_EN undefined:
  - No counter and no ERROR state; error is tied to 0.
  - WAIT_DONE waits indefinitely.

Test Plan:
- Write 3'd6 with magnet=1 at cycle 10 -> direction=8'b0100_0000 for exactly cycle 12; magnet_on=1 from cycle 13. Pulse move_done at 20 for 2 cycles -> one path_done at 21+SETTLE_CYCLES; magnet_on=0 the same cycle.
- Write 17 commands back-to-back with DEPTH=16 and the sequencer held in WAIT_DONE -> cmd_full=1, cmd_count=16, overflow=1; the 17th command is never issued.
- Queue N, NE, S; answer each move_done -> direction pulses 0x01, 0x80, 0x10, each separated by at least SETTLE_CYCLES+2 cycles; a single path_done after the last.
- home_req during WAIT_DONE of move 1 of 2 -> after done_rise and settle, home pulses before move 2; magnet_on=0 during homing; move 2 then issues.
- abort during WAIT_DONE with 5 queued -> cmd_count=0 next cycle; after move_done, state IDLE with no settle gap, no path_done, magnet_on=0.
- MOVE_TIMEOUT_EN with TIMEOUT_CYCLES=100: issue a move and withhold move_done -> error=1 at 100 cycles after WAIT_DONE entry; busy stays 1; reset clears all outputs.

Source files
------------

// File: rtl/move_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : move_sequencer_if
// Brief    : Host-command and motor-controller signal bundle for move_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface move_sequencer_if #(
    parameter int AW = 4
);
    logic [3:0]  cmd_in;
    logic        cmd_wr;
    logic        cmd_full;
    logic [AW:0] cmd_count;
    logic        overflow;
    logic        home_req;
    logic        abort;
    logic [7:0]  direction;
    logic        home;
    logic        move_done;
    logic        magnet_on;
    logic        busy;
    logic        path_done;
    logic        error;

    // Environment side: host writes plus the motor controller's completion pulse
    modport master (
        output cmd_in, cmd_wr, home_req, abort, move_done,
        input  cmd_full, cmd_count, overflow, direction, home,
               magnet_on, busy, path_done, error
    );

    modport slave (
        input  cmd_in, cmd_wr, home_req, abort, move_done,
        output cmd_full, cmd_count, overflow, direction, home,
               magnet_on, busy, path_done, error
    );
endinterface

`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : move_sequencer
// Brief    : Buffers compass-move commands and paces them to the stepper
//            controller with settle gaps, homing and abort handling.
//            Optional watchdog: define MOVE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module move_sequencer #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    move_sequencer_if.slave bus
);

    localparam int              c_settle_w    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [AW:0]     c_depth       = (AW+1)'(DEPTH);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_issue      = 3'd1;
    localparam logic [2:0] c_st_wait_done  = 3'd2;
    localparam logic [2:0] c_st_settle     = 3'd3;
    localparam logic [2:0] c_st_home_issue = 3'd4;
    localparam logic [2:0] c_st_home_wait  = 3'd5;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_timeout;
    logic [3:0]    w_head;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_flush = bus.abort | w_timeout;
    assign w_push  = bus.cmd_wr & ~w_full & ~w_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.cmd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // A write coinciding with a flush is discarded silently
            if (bus.cmd_wr && w_full && !w_flush) begin
                r_overflow <= 1'b1;
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign bus.cmd_full  = w_full;
    assign bus.cmd_count = r_count;
    assign bus.overflow  = r_overflow;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [3:0]            r_cur_cmd;
    logic                  r_move_done_q;
    logic                  r_home_pending;
    logic                  r_abort_pending;
    logic [c_settle_w-1:0] r_settle;
    logic                  r_magnet;
    logic                  r_path_done;
    logic                  w_done_rise;
    logic                  w_abort_any;
    logic                  w_path_done;
    logic                  w_enter_home;

    assign w_done_rise  = bus.move_done & ~r_move_done_q;
    assign w_abort_any  = r_abort_pending | bus.abort;
    assign w_enter_home = (w_next == c_st_home_issue) && (r_state != c_st_home_issue);

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_path_done = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.abort) begin
                    w_next = c_st_idle;
                end else if (r_home_pending) begin
                    w_next = c_st_home_issue;
                end else if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = c_st_issue;
                end
            end
            c_st_issue: begin
                w_next = c_st_wait_done;
            end
            c_st_wait_done, c_st_home_wait: begin
                // An aborted path skips the settle gap once the motion lands
                if (w_done_rise) begin
                    w_next = w_abort_any ? c_st_idle : c_st_settle;
                end
            end
            c_st_settle: begin
                if (bus.abort) begin
                    w_next = c_st_idle;
                end else if (r_settle == '0) begin
                    if (r_home_pending) begin
                        w_next = c_st_home_issue;
                    end else if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = c_st_issue;
                    end else begin
                        w_path_done = 1'b1;
                        w_next      = c_st_idle;
                    end
                end
            end
            c_st_home_issue: begin
                w_next = c_st_home_wait;
            end
`ifdef MOVE_TIMEOUT_EN
            c_st_error: begin
                w_next = c_st_error;
            end
`endif
            default: begin
                w_next = c_st_idle;
            end
        endcase
`ifdef MOVE_TIMEOUT_EN
        if (w_timeout) begin
            w_next = c_st_error;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_cur_cmd       <= '0;
            r_move_done_q   <= 1'b0;
            r_home_pending  <= 1'b0;
            r_abort_pending <= 1'b0;
            r_settle        <= '0;
            r_magnet        <= 1'b0;
            r_path_done     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_move_done_q <= bus.move_done;
            r_path_done   <= w_path_done;

            if (w_pop) begin
                r_cur_cmd <= w_head;
            end

            // A request landing on the entry cycle stays pending for another home
            if (bus.home_req) begin
                r_home_pending <= 1'b1;
            end else if (w_enter_home) begin
                r_home_pending <= 1'b0;
            end

            if (w_next == c_st_idle) begin
                r_abort_pending <= 1'b0;
            end else if (bus.abort && (r_state == c_st_issue || r_state == c_st_wait_done ||
                                       r_state == c_st_home_issue || r_state == c_st_home_wait)) begin
                r_abort_pending <= 1'b1;
            end

            if ((w_next == c_st_settle) && (r_state != c_st_settle)) begin
                r_settle <= c_settle_load;
            end else if ((r_state == c_st_settle) && (r_settle != '0)) begin
                r_settle <= r_settle - 1'b1;
            end

            if ((w_next == c_st_idle) || w_enter_home || w_timeout) begin
                r_magnet <= 1'b0;
            end else if (r_state == c_st_issue) begin
                r_magnet <= r_cur_cmd[3];
            end
        end
    end

    assign bus.direction = (r_state == c_st_issue) ? (8'd1 << r_cur_cmd[2:0]) : 8'd0;
    assign bus.home      = (r_state == c_st_home_issue);
    assign bus.magnet_on = r_magnet;
    assign bus.busy      = (r_state != c_st_idle);
    assign bus.path_done = r_path_done;

    // ------------------------------------------------------------------
    // Move watchdog
    // ------------------------------------------------------------------
`ifdef MOVE_TIMEOUT_EN
    localparam logic [2:0]  c_st_error     = 3'd6;
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_wdog;
    logic        r_error;
    logic        w_in_wait;

    assign w_in_wait = (r_state == c_st_wait_done) || (r_state == c_st_home_wait);
    assign w_timeout = w_in_wait && !w_done_rise && (r_wdog == c_timeout_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_in_wait) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.error = r_error;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign bus.error        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_sequencer
// Brief    : Self-checking bench for move_sequencer against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int SETTLE = 8;
    localparam int BOUND  = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_sequencer_if #(.AW(AW)) bus ();

    move_sequencer #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Observed pulses, stamped with the cycle they were high in
    int         dq_cyc[$];
    logic [7:0] dq_val[$];
    int         hq[$];
    int         pdq[$];
    int         n_viol = 0;
    logic [7:0] prev_dir  = '0;
    logic       prev_home = 1'b0;
    logic       prev_pd   = 1'b0;

    always @(negedge clk) begin
        if (bus.direction !== 8'd0) begin
            dq_cyc.push_back(cyc);
            dq_val.push_back(bus.direction);
        end
        if (bus.home === 1'b1) hq.push_back(cyc);
        if (bus.path_done === 1'b1) pdq.push_back(cyc);
        if ($countones(bus.direction) > 1) n_viol++;
        if (bus.direction !== 8'd0 && bus.home === 1'b1) n_viol++;
        if (bus.direction !== 8'd0 && prev_dir !== 8'd0) n_viol++;
        if (bus.home === 1'b1 && prev_home === 1'b1) n_viol++;
        if (bus.path_done === 1'b1 && (prev_pd === 1'b1 || bus.magnet_on !== 1'b0)) n_viol++;
        prev_dir  = bus.direction;
        prev_home = bus.home;
        prev_pd   = bus.path_done;
    end

    // Reference model: the accepted-but-not-yet-issued commands, in order
    logic [3:0] mq[$];
    logic       cur_mag;
    int         last_rise;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.cmd_in    = '0;
        bus.cmd_wr    = 1'b0;
        bus.home_req  = 1'b0;
        bus.abort     = 1'b0;
        bus.move_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        mq.delete();
        dq_cyc.delete();
        dq_val.delete();
        hq.delete();
        pdq.delete();
    endtask

    task automatic write_cmd(input logic [3:0] c);
        bus.cmd_in = c;
        bus.cmd_wr = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(c);
        tick();
        bus.cmd_wr = 1'b0;
    endtask

    task automatic wait_pulse(input int exp_cyc);
        int         k;
        int         c;
        logic [7:0] v;
        logic [3:0] e;
        k = 0;
        while (dq_cyc.size() == 0 && k < BOUND) begin
            tick();
            k++;
        end
        check("pulse_seen", 32'(dq_cyc.size() > 0), 32'd1);
        if (dq_cyc.size() > 0) begin
            c = dq_cyc.pop_front();
            v = dq_val.pop_front();
            e = (mq.size() > 0) ? mq.pop_front() : 4'h0;
            check("direction", 32'(v), 32'(8'd1 << e[2:0]));
            if (exp_cyc >= 0) check("pulse_cycle", 32'(c), 32'(exp_cyc));
            cur_mag = e[3];
        end
    endtask

    task automatic answer();
        int w;
        w = $urandom_range(1, 4);
        repeat (w) tick();
        check("magnet_move", 32'(bus.magnet_on), 32'(cur_mag));
        bus.move_done = 1'b1;
        last_rise     = cyc;
        tick();
        if ($urandom_range(0, 1) == 1) tick();
        bus.move_done = 1'b0;
    endtask

    task automatic finish_path();
        int k;
        k = 0;
        while (pdq.size() == 0 && k < BOUND) begin
            tick();
            k++;
        end
        check("path_done_seen", 32'(pdq.size() > 0), 32'd1);
        if (pdq.size() > 0) check("path_done_cycle", 32'(pdq.pop_front()), 32'(last_rise + SETTLE + 1));
        repeat (4) tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_magnet", 32'(bus.magnet_on), 32'd0);
        check("no_extra_pulses", 32'(dq_cyc.size() + pdq.size()), 32'd0);
    endtask

    task automatic run_queued(input int first_exp);
        wait_pulse(first_exp);
        answer();
        while (mq.size() > 0) begin
            wait_pulse(last_rise + SETTLE + 1);
            answer();
        end
        finish_path();
    endtask

    initial begin
        int         t;
        int         n;
        logic [3:0] c;

        // Reset state
        do_reset();
        check("rst_direction", 32'(bus.direction), 32'd0);
        check("rst_home", 32'(bus.home), 32'd0);
        check("rst_count", 32'(bus.cmd_count), 32'd0);
        check("rst_full", 32'(bus.cmd_full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_magnet", 32'(bus.magnet_on), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_path_done", 32'(bus.path_done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);

        // Single move: East with magnet, write-to-pulse latency of two cycles
        repeat (3) tick();
        t = cyc;
        write_cmd(4'b1110);
        check("count_after_write", 32'(bus.cmd_count), 32'd1);
        run_queued(t + 2);

        // Overflow while a move is outstanding
        do_reset();
        t = cyc;
        write_cmd(4'($urandom));
        wait_pulse(t + 2);
        for (int i = 0; i < 17; i++) write_cmd(4'($urandom));
        check("full_count", 32'(bus.cmd_count), 32'd16);
        check("full_flag", 32'(bus.cmd_full), 32'd1);
        check("overflow_flag", 32'(bus.overflow), 32'd1);
        answer();
        while (mq.size() > 0) begin
            wait_pulse(last_rise + SETTLE + 1);
            answer();
        end
        finish_path();

        // Directed N, NE, S path
        do_reset();
        t = cyc;
        write_cmd({1'($urandom), 3'd0});
        write_cmd({1'($urandom), 3'd7});
        write_cmd({1'($urandom), 3'd4});
        run_queued(t + 2);

        // Homing requested mid-path goes ahead of the second move
        do_reset();
        t = cyc;
        write_cmd(4'b1000 | 4'($urandom_range(0, 7)));
        write_cmd(4'($urandom));
        wait_pulse(t + 2);
        bus.home_req = 1'b1;
        tick();
        bus.home_req = 1'b0;
        answer();
        n = 0;
        while (hq.size() == 0 && n < BOUND) begin
            tick();
            n++;
        end
        check("home_seen", 32'(hq.size() > 0), 32'd1);
        if (hq.size() > 0) check("home_cycle", 32'(hq.pop_front()), 32'(last_rise + SETTLE + 1));
        tick();
        check("home_magnet", 32'(bus.magnet_on), 32'd0);
        check("home_before_move2", 32'(dq_cyc.size()), 32'd0);
        check("home_count", 32'(bus.cmd_count), 32'd1);
        repeat (2) tick();
        bus.move_done = 1'b1;
        last_rise     = cyc;
        tick();
        bus.move_done = 1'b0;
        wait_pulse(last_rise + SETTLE + 1);
        answer();
        finish_path();

        // Abort with five queued, plus a write dropped in the abort cycle
        do_reset();
        t = cyc;
        for (int i = 0; i < 6; i++) write_cmd(4'($urandom));
        wait_pulse(t + 2);
        tick();
        check("abort_pre_count", 32'(bus.cmd_count), 32'd5);
        bus.abort  = 1'b1;
        bus.cmd_wr = 1'b1;
        bus.cmd_in = 4'($urandom);
        tick();
        bus.abort  = 1'b0;
        bus.cmd_wr = 1'b0;
        mq.delete();
        check("abort_count", 32'(bus.cmd_count), 32'd0);
        check("abort_no_overflow", 32'(bus.overflow), 32'd0);
        check("abort_busy_moving", 32'(bus.busy), 32'd1);
        answer();
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_magnet", 32'(bus.magnet_on), 32'd0);
        repeat (SETTLE + 6) tick();
        check("abort_quiet", 32'(dq_cyc.size() + pdq.size() + hq.size()), 32'd0);

        // Random paths
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            t = cyc;
            for (int i = 0; i < n; i++) write_cmd(4'($urandom));
            run_queued(t + 2);
        end

        check("pulse_invariants", 32'(n_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
